cla_addsub_pipe: RTL and testbench
==================================

# cla_addsub_pipe

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshake. It replaces the fixed 4-bit registered adder in the NPC datapath. Operand width, lookahead group size and pipeline depth are configurable. It produces sum, carry-out, signed overflow and zero flags, and accepts one operation per cycle.

## Interface
- WIDTH, 32: operand/result width in bits; must be a multiple of NSEG*GRP.
- GRP, 4: carry-lookahead group size in bits; carries are flattened within a group and rippled between groups.
- NSEG, 2: number of pipeline segments; valid range is 1..8.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  the input operation is valid.
- in_ready  out  1  the block can accept an input this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; acts as borrow-in when sub=1.
- sub  in  1  0: A+B+cin; 1: A−B−cin.
- out_valid  out  1  the result is valid.
- out_ready  in  1  the consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB; for subtraction, 1 means no borrow.
- overflow  out  1  signed overflow.
- zero  out  1  sum == 0.

## Operation
- Effective B: bx = sub ? ~b : b.
- Effective carry-in: c0 = cin ^ sub.
- Segment width: SW = WIDTH/NSEG. Segment k covers bits [k*SW +: SW].
- Per bit: g = a & bx, p = a | bx. Sum bit = a ^ bx ^ c.
- Pipeline stage k (k = 0..NSEG−1) computes segment k from the carry registered by stage k−1. Stage 0 uses c0.
- Segments are delay-matched:
  - Operand bits of segments not yet computed travel forward in skew registers.
  - Sum bits already computed travel forward to the output.
- Final stage outputs:
  - cout = carry out of bit WIDTH−1.
  - overflow = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
  - zero = ~|sum.
- Each stage has a valid bit. All stages advance together on en = ~out_valid | out_ready. in_ready = en.
- An input is accepted when in_valid & in_ready. When en is low, every stage register, including data, holds.
- Bubbles (valid=0) are not collapsed. They advance like data.
- There is no state machine. Pipeline occupancy is defined solely by the stage valid bits.

## Timing
- Latency: an input accepted at edge t appears on out_valid/sum at edge t+NSEG, given no stalls.
- Throughput: 1 operation per cycle while out_ready=1.
- out_valid/sum/cout/overflow/zero are registered. Nothing passes combinationally from a/b to the outputs.
- in_ready depends combinationally on out_ready only.
- Stall:
  - out_valid=1 & out_ready=0 freezes the whole pipeline.
  - Outputs hold stable until the handshake completes.
  - Stage contents are never overwritten or dropped.
- Simultaneous events: the output handshake and a new input in the same cycle complete together. Full throughput is preserved.
- Data and flag fields are don't-care while their valid bit is 0. The implementation still zeroes them on reset.
- Reset:
  - In the cycle rst=1, all stage valid bits, out_valid, sum, cout, overflow, zero and carry registers clear to 0 on the edge.
  - in_ready is 1 in the first cycle after reset.
  - Reset during an operation flushes in-flight operations; none are delivered.
  - rst overrides en.
- Wrap-around: the sum is modulo 2^WIDTH. The carry is reported only via cout.

## Test plan
Parameters WIDTH=8, GRP=4, NSEG=2, out_ready=1 unless noted.
- **Signed overflow:** a=8'h7F, b=8'h01, cin=0, sub=0 → two cycles later sum=8'h80, cout=0, overflow=1, zero=0.
- **Carry wrap:** a=8'hFF, b=8'h01, cin=0, sub=0 → sum=8'h00, cout=1, overflow=0, zero=1.
- **Subtraction and borrow:**
  - a=8'h05, b=8'h07, sub=1, cin=0 → sum=8'hFE, cout=0, overflow=0.
  - a=8'h80, b=8'h01, sub=1 → sum=8'h7F, overflow=1, cout=1.
- **Back-to-back with stall:** send 4 consecutive ops; hold out_ready=0 for 3 cycles after the first result.
  - Required: in_ready=0 during the stall and outputs stable.
  - Required: all 4 results arrive in order, with none lost or duplicated.
- **Reset mid-flight:** accept 2 ops, assert rst for 1 cycle → out_valid stays 0 and both ops are discarded. A new op after reset returns its correct result at latency 2.
- **Random regression:** WIDTH=32, NSEG∈{1,2,4}, random valid/ready toggling → each result matches {cout,sum} = a + bx + c0 and the overflow/zero reference model, in input order.

Source files
------------

// File: rtl/cla_addsub_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : cla_addsub_pipe_if
// Purpose  : Operand / result handshake bundle for cla_addsub_pipe.
// Revision : 1.0 - initial release
// ============================================================================
interface cla_addsub_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow, zero
  );
endinterface
`default_nettype wire

// File: rtl/cla_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cla_addsub_pipe
// Purpose  : Pipelined carry-lookahead adder/subtractor, one segment per stage,
//            with a registered result/flag rank and valid/ready flow control.
// Revision : 1.0 - initial release
// ============================================================================
module cla_addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int GRP   = 4,
  parameter int NSEG  = 2
) (
  input  logic             clk,
  input  logic             rst,
  cla_addsub_pipe_if.slave bus
);

  localparam int SW   = WIDTH / NSEG;
  localparam int NGRP = SW / GRP;

  if (NSEG < 1 || NSEG > 8 || (WIDTH % (NSEG * GRP)) != 0) begin : g_bad_params
    $error("cla_addsub_pipe: NSEG must be 1..8 and WIDTH a multiple of NSEG*GRP");
  end

  logic             en;
  logic             out_vld_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ov_q;
  logic             zero_q;

  // Every rank advances together; a held result freezes the whole pipe.
  assign en           = ~out_vld_q | bus.out_ready;
  assign bus.in_ready = en;

  // Carries c[0..SW] of one segment: flattened lookahead inside each group,
  // ripple from group to group.
  function automatic logic [SW:0] seg_carries(input logic [SW-1:0] sa,
                                              input logic [SW-1:0] sbx,
                                              input logic          ci);
    logic [SW:0]    c;
    logic [GRP-1:0] gg;
    logic [GRP-1:0] pp;
    logic           acc;
    logic           term;
    c    = '0;
    c[0] = ci;
    for (int grp = 0; grp < NGRP; grp++) begin
      gg = sa[grp*GRP +: GRP] & sbx[grp*GRP +: GRP];
      pp = sa[grp*GRP +: GRP] | sbx[grp*GRP +: GRP];
      for (int i = 1; i <= GRP; i++) begin
        acc = c[grp*GRP];
        for (int j = 0; j < i; j++) begin
          acc = acc & pp[j];
        end
        for (int j = 0; j < i; j++) begin
          term = gg[j];
          for (int m = j + 1; m < i; m++) begin
            term = term & pp[m];
          end
          acc = acc | term;
        end
        c[grp*GRP + i] = acc;
      end
    end
    return c;
  endfunction

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int REM  = WIDTH - k * SW;  // operand bits from this segment up
    localparam int DONE = (k + 1) * SW;    // result bits known after this stage

    logic            vld_in;
    logic [REM-1:0]  a_in;
    logic [REM-1:0]  bx_in;
    logic            c_in;
    logic [SW:0]     car;
    logic [SW-1:0]   seg_sum;
    logic [DONE-1:0] s_d;
    logic            vld_q;
    logic            c_q;
    logic [DONE-1:0] s_q;

    if (k == 0) begin : g_head
      assign vld_in = bus.in_valid;
      assign a_in   = bus.a;
      assign bx_in  = bus.sub ? ~bus.b : bus.b;
      assign c_in   = bus.cin ^ bus.sub;
      assign s_d    = seg_sum;
    end else begin : g_body
      assign vld_in = g_stage[k-1].vld_q;
      assign a_in   = g_stage[k-1].g_skew.a_q;
      assign bx_in  = g_stage[k-1].g_skew.bx_q;
      assign c_in   = g_stage[k-1].c_q;
      assign s_d    = {seg_sum, g_stage[k-1].s_q};
    end

    assign car     = seg_carries(a_in[SW-1:0], bx_in[SW-1:0], c_in);
    assign seg_sum = a_in[SW-1:0] ^ bx_in[SW-1:0] ^ car[SW-1:0];

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        s_q   <= '0;
      end else if (en) begin
        vld_q <= vld_in;
        c_q   <= car[SW];
        s_q   <= s_d;
      end
    end

    if (k < NSEG - 1) begin : g_skew
      logic [REM-SW-1:0] a_q;
      logic [REM-SW-1:0] bx_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q  <= '0;
          bx_q <= '0;
        end else if (en) begin
          a_q  <= a_in[REM-1:SW];
          bx_q <= bx_in[REM-1:SW];
        end
      end
    end else begin : g_tail
      // Carry into the MSB is kept for the signed-overflow flag.
      logic cm_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          cm_q <= 1'b0;
        end else if (en) begin
          cm_q <= car[SW-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ov_q      <= 1'b0;
      zero_q    <= 1'b0;
    end else if (en) begin
      out_vld_q <= g_stage[NSEG-1].vld_q;
      sum_q     <= g_stage[NSEG-1].s_q;
      cout_q    <= g_stage[NSEG-1].c_q;
      ov_q      <= g_stage[NSEG-1].g_tail.cm_q ^ g_stage[NSEG-1].c_q;
      zero_q    <= ~|g_stage[NSEG-1].s_q;
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ov_q;
  assign bus.zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_addsub_pipe
// Purpose  : Directed 8-bit vectors plus 32-bit random traffic on NSEG=1/2/4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_addsub_pipe;

  logic clk = 1'b0;
  logic rst;
  logic rrst;
  logic rnd_go = 1'b0;
  int   rnd_done = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  cla_addsub_pipe_if #(.WIDTH(8)) d8 ();

  cla_addsub_pipe #(.WIDTH(8), .GRP(4), .NSEG(2)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (d8)
  );

  logic [10:0] res8;
  assign res8 = {d8.cout, d8.overflow, d8.zero, d8.sum};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Directed vector table: expected is {cout, overflow, zero, sum}.
  logic [7:0]  da   [12];
  logic [7:0]  db   [12];
  logic        dc   [12];
  logic        ds   [12];
  logic [10:0] dexp [12];

  task automatic set8(input int i, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic s, input logic [10:0] e);
    da[i] = a; db[i] = b; dc[i] = c; ds[i] = s; dexp[i] = e;
  endtask

  task automatic run8(input string tag, input int base, input int nops, input int stall);
    int sent, got_n, cyc, stall_left, acc0;
    bit seen;
    sent = 0; got_n = 0; cyc = 0; stall_left = 0; acc0 = 0; seen = 0;
    while (got_n < nops && cyc < 40) begin
      @(negedge clk);
      if (!seen && d8.out_valid) begin
        seen = 1;
        stall_left = stall;
      end
      d8.out_ready = (stall_left == 0);
      d8.in_valid  = (sent < nops);
      if (sent < nops) begin
        d8.a   = da[base+sent];
        d8.b   = db[base+sent];
        d8.cin = dc[base+sent];
        d8.sub = ds[base+sent];
      end
      #1;
      if (stall_left > 0) begin
        check_eq({tag, "_stall_rdy"}, 64'(d8.in_ready), 64'd0);
        check_eq({tag, "_stall_hold"}, {d8.out_valid, res8}, {1'b1, dexp[base+got_n]});
        stall_left--;
      end
      if (d8.out_valid && d8.out_ready) begin
        check_eq({tag, "_res"}, res8, dexp[base+got_n]);
        if (got_n == 0 && stall == 0) check_eq({tag, "_lat"}, cyc - acc0 - 1, 2);
        got_n++;
      end
      if (d8.in_valid && d8.in_ready) begin
        if (sent == 0) acc0 = cyc;
        sent++;
      end
      cyc++;
    end
    check_eq({tag, "_count"}, got_n, nops);
    d8.in_valid  = 1'b0;
    d8.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 check_eq({tag, "_nodup"}, 64'(d8.out_valid), 64'd0);
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
    localparam int NS = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);

    cla_addsub_pipe_if #(.WIDTH(32)) rif ();

    cla_addsub_pipe #(.WIDTH(32), .GRP(4), .NSEG(NS)) u_dut (
      .clk (clk),
      .rst (rrst),
      .bus (rif)
    );

    initial begin : p_rnd
      logic [34:0] sb[$];
      logic [31:0] bx;
      logic [32:0] full;
      logic [34:0] e;
      logic        ovf;
      int          acc_n;
      int          cyc;
      string       tag;
      tag = $sformatf("rnd_nseg%0d", NS);
      rif.in_valid = 1'b0; rif.out_ready = 1'b0;
      rif.a = '0; rif.b = '0; rif.cin = 1'b0; rif.sub = 1'b0;
      wait (rnd_go);
      acc_n = 0; cyc = 0;
      while ((acc_n < 40 || sb.size() != 0) && cyc < 1000) begin
        @(negedge clk);
        rif.out_ready = ($urandom_range(0, 3) != 0);
        rif.in_valid  = (acc_n < 40) && ($urandom_range(0, 3) != 0);
        rif.a   = $urandom;
        rif.b   = $urandom;
        rif.cin = 1'($urandom_range(0, 1));
        rif.sub = 1'($urandom_range(0, 1));
        #1;
        if (rif.out_valid && rif.out_ready) begin
          if (sb.size() == 0) check_eq({tag, "_extra"}, 64'(sb.size()), 64'd1);
          else check_eq({tag, "_res"}, {rif.cout, rif.overflow, rif.zero, rif.sum}, sb.pop_front());
        end
        if (rif.in_valid && rif.in_ready) begin
          bx   = rif.sub ? ~rif.b : rif.b;
          full = {1'b0, rif.a} + {1'b0, bx} + 33'(rif.cin ^ rif.sub);
          ovf  = (rif.a[31] == bx[31]) && (full[31] != rif.a[31]);
          e    = {full[32], ovf, (full[31:0] == 32'd0), full[31:0]};
          sb.push_back(e);
          acc_n++;
        end
        cyc++;
      end
      check_eq({tag, "_drain"}, 64'(sb.size()), 64'd0);
      check_eq({tag, "_sent"}, acc_n, 40);
      rnd_done++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rrst = 1'b1;
    d8.in_valid = 1'b0; d8.out_ready = 1'b1;
    d8.a = '0; d8.b = '0; d8.cin = 1'b0; d8.sub = 1'b0;

    set8(0,  8'h7F, 8'h01, 1'b0, 1'b0, 11'h280);
    set8(1,  8'hFF, 8'h01, 1'b0, 1'b0, 11'h500);
    set8(2,  8'h05, 8'h07, 1'b0, 1'b1, 11'h0FE);
    set8(3,  8'h80, 8'h01, 1'b0, 1'b1, 11'h67F);
    set8(4,  8'h10, 8'h03, 1'b1, 1'b1, 11'h40C);
    set8(5,  8'h0F, 8'hF0, 1'b1, 1'b0, 11'h500);
    set8(6,  8'h80, 8'h80, 1'b0, 1'b0, 11'h700);
    set8(7,  8'h01, 8'h02, 1'b0, 1'b0, 11'h003);
    set8(8,  8'h10, 8'h20, 1'b0, 1'b0, 11'h030);
    set8(9,  8'hFF, 8'hFF, 1'b0, 1'b0, 11'h4FE);
    set8(10, 8'h50, 8'h60, 1'b0, 1'b1, 11'h0F0);
    set8(11, 8'h33, 8'h44, 1'b0, 1'b0, 11'h077);

    repeat (3) @(negedge clk);
    rst = 1'b0; rrst = 1'b0; rnd_go = 1'b1;
    #1;
    check_eq("reset_out_valid", 64'(d8.out_valid), 64'd0);
    check_eq("reset_in_ready", 64'(d8.in_ready), 64'd1);
    check_eq("reset_result", 64'(res8), 64'd0);

    for (int i = 0; i < 7; i++) run8($sformatf("op%0d", i), i, 1, 0);

    run8("b2b_stall", 7, 4, 3);

    @(negedge clk);
    d8.out_ready = 1'b1; d8.in_valid = 1'b1;
    d8.a = 8'h11; d8.b = 8'h22; d8.cin = 1'b0; d8.sub = 1'b0;
    @(negedge clk);
    d8.a = 8'h5A; d8.b = 8'h0F;
    @(negedge clk);
    d8.in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 check_eq("rst_in_ready", 64'(d8.in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      #1 check_eq($sformatf("rst_flush%0d", i), 64'(d8.out_valid), 64'd0);
      @(negedge clk);
    end
    run8("post_rst", 11, 1, 0);

    wait (rnd_done == 3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
